// File: rtl/trap_ctrl_if.sv
// Pipeline/CSR-file/fetch signals of the trap sequencer, grouped as one bundle.
// "master" is the pipeline/CSR side; "slave" is the trap sequencer itself.
interface trap_ctrl_if #(
  parameter int MXLEN = 32,
  parameter int CNT_W = 16
);
  logic             instr_valid;
  logic [MXLEN-1:0] instr;
  logic [MXLEN-1:0] pc;
  logic [MXLEN-1:0] mem_addr;
  logic [8:0]       exc_flags;
  logic             mret_req;
  logic [2:0]       irq_pend;
  logic [2:0]       irq_en;
  logic             mstatus_mie;
  logic [MXLEN-1:0] csr_rdata;
  logic             csr_exception;
  logic             csr_mret;
  logic             csr_read;
  logic [MXLEN-1:0] csr_cause;
  logic [MXLEN-1:0] csr_pc;
  logic [MXLEN-1:0] csr_instr;
  logic [MXLEN-1:0] csr_addr_out;
  logic             stall;
  logic             flush;
  logic             redir_valid;
  logic [MXLEN-1:0] redir_pc;
  logic             redir_ready;
  logic [CNT_W-1:0] trap_cnt;

  modport master (
    output instr_valid, instr, pc, mem_addr, exc_flags, mret_req,
           irq_pend, irq_en, mstatus_mie, csr_rdata, redir_ready,
    input  csr_exception, csr_mret, csr_read, csr_cause, csr_pc, csr_instr,
           csr_addr_out, stall, flush, redir_valid, redir_pc, trap_cnt
  );

  modport slave (
    input  instr_valid, instr, pc, mem_addr, exc_flags, mret_req,
           irq_pend, irq_en, mstatus_mie, csr_rdata, redir_ready,
    output csr_exception, csr_mret, csr_read, csr_cause, csr_pc, csr_instr,
           csr_addr_out, stall, flush, redir_valid, redir_pc, trap_cnt
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: picks one interrupt/exception/MRET at the commit boundary,
// strobes the CSR file for one cycle, then hands fetch a flush plus PC redirect.
module trap_ctrl #(
  parameter int MXLEN = 32,
  parameter int CNT_W = 16
) (
  input logic         CLK,
  input logic         RST,
  trap_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CSR_OP, REDIR} state_t;

  state_t           state, state_nxt;
  logic [2:0]       irq_act;
  logic             any_exc;
  logic             take;
  logic [MXLEN-1:0] cause_sel;
  logic             mret_sel;
  logic [MXLEN-1:0] addr_sel;

  logic [MXLEN-1:0] cause_p1, pc_p1, instr_p1, addr_p1;
  logic             mret_p1;
  logic [MXLEN-1:0] redir_pc_p2;
  logic [CNT_W-1:0] cnt;

  // Interrupt codes carry the MSB; exceptions are listed highest priority first.
  function automatic logic [MXLEN-1:0] pick_cause(input logic [2:0] irq, input logic [8:0] exc);
    logic [MXLEN-1:0] c;
    c = '0;
    if      (irq[2]) begin c = MXLEN'(11); c[MXLEN-1] = 1'b1; end
    else if (irq[0]) begin c = MXLEN'(3);  c[MXLEN-1] = 1'b1; end
    else if (irq[1]) begin c = MXLEN'(7);  c[MXLEN-1] = 1'b1; end
    else if (exc[0]) c = MXLEN'(1);
    else if (exc[1]) c = MXLEN'(2);
    else if (exc[2]) c = MXLEN'(0);
    else if (exc[3]) c = MXLEN'(11);
    else if (exc[4]) c = MXLEN'(3);
    else if (exc[5]) c = MXLEN'(4);
    else if (exc[6]) c = MXLEN'(6);
    else if (exc[7]) c = MXLEN'(5);
    else if (exc[8]) c = MXLEN'(7);
    return c;
  endfunction

  assign irq_act   = bus.irq_pend & bus.irq_en & {3{bus.mstatus_mie}};
  assign any_exc   = (|irq_act) | (|bus.exc_flags);
  assign take      = (state == IDLE) & bus.instr_valid & (any_exc | bus.mret_req);
  assign cause_sel = pick_cause(irq_act, bus.exc_flags);
  assign mret_sel  = ~any_exc & bus.mret_req;
  // Only load/store causes (4..7) carry a faulting address into mtval.
  assign addr_sel  = (cause_sel >= MXLEN'(4) && cause_sel <= MXLEN'(7)) ? bus.mem_addr : '0;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    bus.csr_exception = 1'b0;
    bus.csr_mret      = 1'b0;
    bus.csr_read      = 1'b0;
    bus.csr_cause     = '0;
    bus.csr_pc        = '0;
    bus.csr_instr     = '0;
    bus.csr_addr_out  = '0;
    bus.redir_valid   = 1'b0;
    bus.flush         = 1'b0;
    bus.stall         = take | (state != IDLE);
    case (state)
      IDLE: if (take) state_nxt = CSR_OP;
      CSR_OP: begin
        bus.csr_read      = 1'b1;
        bus.csr_exception = ~mret_p1;
        bus.csr_mret      = mret_p1;
        bus.csr_cause     = cause_p1;
        bus.csr_pc        = pc_p1;
        bus.csr_instr     = instr_p1;
        bus.csr_addr_out  = addr_p1;
        state_nxt         = REDIR;
      end
      REDIR: begin
        bus.redir_valid = 1'b1;
        bus.flush       = 1'b1;
        if (bus.redir_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p1: trap record captured in the detect cycle; p2: CSR read data captured in CSR_OP.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cause_p1    <= '0;
      pc_p1       <= '0;
      instr_p1    <= '0;
      addr_p1     <= '0;
      mret_p1     <= 1'b0;
      redir_pc_p2 <= '0;
      cnt         <= '0;
    end else begin
      if (take) begin
        cause_p1 <= mret_sel ? '0 : cause_sel;
        pc_p1    <= bus.pc;
        instr_p1 <= bus.instr;
        addr_p1  <= mret_sel ? '0 : addr_sel;
        mret_p1  <= mret_sel;
      end
      if (state == CSR_OP) redir_pc_p2 <= bus.csr_rdata;
      if (state == REDIR && bus.redir_ready) cnt <= cnt + 1'b1;
    end
  end

  assign bus.redir_pc = redir_pc_p2;
  assign bus.trap_cnt = cnt;

endmodule
